// File: rtl/gray_count_rx_if.sv
// Handshake bundle for the Gray-count receiver: the remote count and controls in,
// the decoded count, step strobes and error status out.
interface gray_count_rx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic             en;
    logic             clr_err;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic             up_pulse;
    logic             dn_pulse;
    logic             wrap_pulse;
    logic             step_err;
    logic             fault;
    logic [3:0]       err_cnt;

    modport master (
        output gray_in, en, clr_err,
        input  bin_out, bin_valid, up_pulse, dn_pulse, wrap_pulse, step_err, fault, err_cnt
    );

    modport slave (
        input  gray_in, en, clr_err,
        output bin_out, bin_valid, up_pulse, dn_pulse, wrap_pulse, step_err, fault, err_cnt
    );
endinterface

// File: rtl/gray_count_rx.sv
// Receives a Gray-coded count from another clock domain, decodes it to binary and
// classifies every sample-to-sample change as hold, +1/-1 step or illegal jump.
module gray_count_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst_n,
    gray_count_rx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, FAULT} state_t;

    state_t                            state;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  g_s;
    logic [WIDTH-1:0]                  g_p;
    logic [WIDTH-1:0]                  bin_s;
    logic [WIDTH-1:0]                  bin_p;
    logic                              one_bit;
    logic                              multi_bit;
    logic                              is_up;
    logic                              err_event;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign g_s       = sync_q[SYNC_STAGES-1];
    assign bin_s     = gray2bin(g_s);
    assign bin_p     = gray2bin(g_p);
    assign one_bit   = ($countones(g_s ^ g_p) == 1);
    assign multi_bit = ($countones(g_s ^ g_p) > 1);
    assign is_up     = (bin_s == bin_p + WIDTH'(1));
    // A jump counts as an error only while the sample stream is being judged.
    assign err_event = bus.en && multi_bit && (state == TRACK || state == FAULT);

    // NOTE: every flop, synchronizer stages included, is cleared by the async reset and
    // updated with non-blocking assignments so all reads below see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            sync_q         <= '0;
            g_p            <= '0;
            bus.bin_out    <= '0;
            bus.bin_valid  <= 1'b0;
            bus.up_pulse   <= 1'b0;
            bus.dn_pulse   <= 1'b0;
            bus.wrap_pulse <= 1'b0;
            bus.step_err   <= 1'b0;
            bus.fault      <= 1'b0;
            bus.err_cnt    <= '0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], bus.gray_in};
            g_p            <= g_s;
            bus.bin_out    <= bin_s;
            bus.up_pulse   <= 1'b0;
            bus.dn_pulse   <= 1'b0;
            bus.wrap_pulse <= 1'b0;
            bus.step_err   <= 1'b0;

            if (!bus.en) begin
                state         <= IDLE;
                bus.bin_valid <= 1'b0;
                bus.fault     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        state         <= TRACK;
                        bus.bin_valid <= 1'b1;
                    end
                    TRACK: begin
                        if (multi_bit) begin
                            state         <= FAULT;
                            bus.bin_valid <= 1'b0;
                            bus.fault     <= 1'b1;
                            bus.step_err  <= 1'b1;
                        end else if (one_bit) begin
                            bus.up_pulse   <= is_up;
                            bus.dn_pulse   <= !is_up;
                            bus.wrap_pulse <= is_up ? (bin_p == '1) : (bin_p == '0);
                        end
                    end
                    FAULT: begin
                        if (bus.clr_err) begin
                            state     <= ACQUIRE;
                            bus.fault <= 1'b0;
                        end else if (multi_bit) begin
                            bus.step_err <= 1'b1;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        bus.bin_valid <= 1'b0;
                        bus.fault     <= 1'b0;
                    end
                endcase
            end

            // A clear request beats a coincident error event.
            if (bus.clr_err) begin
                bus.err_cnt <= '0;
            end else if (err_event && bus.err_cnt != 4'hF) begin
                bus.err_cnt <= bus.err_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_gray_count_rx.sv
// Bench for gray_count_rx: a sample-history model is compared against the DUT every
// cycle, with directed scenarios pinned by literal expectations plus a random phase.
module tb_gray_count_rx;

    localparam int W = 4;
    localparam int S = 2;
    localparam int M = 1 << W;

    typedef enum {M_IDLE, M_ACQ, M_TRACK, M_FAULT} mode_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    gray_count_rx_if #(.WIDTH(W)) bus ();

    gray_count_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: history of gray_in taken at each edge, newest first.
    int    q[$];
    mode_t mode;
    int    e_bin, e_up, e_dn, e_wrap, e_step, e_cnt;
    int    up_seen = 0, dn_seen = 0, wrap_seen = 0, step_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = g; s != 0; s = s >> 1) b = b ^ s;
        return b;
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        q.delete();
        repeat (S + 2) q.push_front(0);
        mode   = M_IDLE;
        e_bin  = 0;
        e_up   = 0;
        e_dn   = 0;
        e_wrap = 0;
        e_step = 0;
        e_cnt  = 0;
    endtask

    task automatic model_step();
        int cur, prv, d, bc, bp;
        q.push_front(int'(bus.gray_in));
        void'(q.pop_back());
        cur    = q[S];
        prv    = q[S+1];
        d      = $countones(cur ^ prv);
        bc     = g2b(cur);
        bp     = g2b(prv);
        e_bin  = bc;
        e_up   = 0;
        e_dn   = 0;
        e_wrap = 0;
        e_step = 0;
        if (!bus.en) begin
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: mode = M_ACQ;
                M_ACQ:  mode = M_TRACK;
                M_TRACK: begin
                    if (d >= 2) begin
                        e_step = 1;
                        if (e_cnt < 15) e_cnt++;
                        mode = M_FAULT;
                    end else if (d == 1) begin
                        if (bc == (bp + 1) % M) begin
                            e_up   = 1;
                            e_wrap = (bp == M - 1);
                        end else begin
                            e_dn   = 1;
                            e_wrap = (bp == 0);
                        end
                    end
                end
                M_FAULT: begin
                    if (bus.clr_err) begin
                        mode = M_ACQ;
                    end else if (d >= 2) begin
                        e_step = 1;
                        if (e_cnt < 15) e_cnt++;
                    end
                end
            endcase
        end
        if (bus.clr_err) e_cnt = 0;
    endtask

    // Model advances at the edge, outputs are compared 4 ns later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1) model_step();
            #4;
            if (rst_n !== 1'b1) model_reset();
            check("bin_out",    bus.bin_out,    e_bin);
            check("bin_valid",  bus.bin_valid,  (mode == M_TRACK));
            check("fault",      bus.fault,      (mode == M_FAULT));
            check("up_pulse",   bus.up_pulse,   e_up);
            check("dn_pulse",   bus.dn_pulse,   e_dn);
            check("wrap_pulse", bus.wrap_pulse, e_wrap);
            check("step_err",   bus.step_err,   e_step);
            check("err_cnt",    bus.err_cnt,    e_cnt);
            up_seen   += int'(bus.up_pulse);
            dn_seen   += int'(bus.dn_pulse);
            wrap_seen += int'(bus.wrap_pulse);
            step_seen += int'(bus.step_err);
        end
    end

    task automatic set_gray(input int b, input int hold);
        bus.gray_in = W'(b2g(b));
        repeat (hold) @(negedge clk);
    endtask

    task automatic set_raw(input int g, input int hold);
        bus.gray_in = W'(g);
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        int u0, d0, w0, s0;
        rst_n       = 1'b0;
        bus.gray_in = '0;
        bus.en      = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bin_out", bus.bin_out, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_valid",   bus.bin_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Upward walk through the whole code space.
        bus.en = 1'b1;
        repeat (3) @(negedge clk);
        check("acq_valid", bus.bin_valid, 1);
        u0 = up_seen;
        s0 = step_seen;
        for (int b = 1; b < M; b++) set_gray(b, 4);
        check("walk_bin",   bus.bin_out, 15);
        check("walk_model", e_bin, 15);
        check("walk_ups",   up_seen - u0, 15);
        check("walk_errs",  step_seen - s0, 0);

        // Wrap in both directions.
        u0 = up_seen;
        w0 = wrap_seen;
        set_gray(0, 4);
        check("wrap_up_cnt",  up_seen - u0, 1);
        check("wrap_up_wrap", wrap_seen - w0, 1);
        check("wrap_up_bin",  bus.bin_out, 0);
        d0 = dn_seen;
        w0 = wrap_seen;
        set_gray(15, 4);
        check("wrap_dn_cnt",  dn_seen - d0, 1);
        check("wrap_dn_wrap", wrap_seen - w0, 1);
        check("wrap_dn_bin",  bus.bin_out, 15);
        for (int b = 14; b >= 2; b--) set_gray(b, 4);

        // Illegal jump 0011 -> 0110, then clear.
        s0 = step_seen;
        set_raw(4'b0110, 4);
        check("jump_step",  step_seen - s0, 1);
        check("jump_cnt",   bus.err_cnt, 1);
        check("jump_fault", bus.fault, 1);
        check("jump_valid", bus.bin_valid, 0);
        check("jump_bin",   bus.bin_out, 4);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("clr_fault", bus.fault, 0);
        check("clr_valid", bus.bin_valid, 0);
        check("clr_cnt",   bus.err_cnt, 0);
        @(negedge clk);
        check("clr_track", bus.bin_valid, 1);

        // Twenty jumps saturate the counter.
        for (int j = 0; j < 20; j++) set_raw((j % 2 == 1) ? 4'b0011 : 4'b0000, 4);
        check("sat_cnt",   bus.err_cnt, 15);
        check("sat_fault", bus.fault, 1);
        s0 = step_seen;
        bus.gray_in = 4'b0000;
        repeat (S) @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("race_cnt",   bus.err_cnt, 0);
        check("race_fault", bus.fault, 0);
        check("race_valid", bus.bin_valid, 0);
        check("race_step",  step_seen - s0, 0);
        @(negedge clk);
        check("race_track", bus.bin_valid, 1);

        // err_cnt survives a trip through IDLE; en dropped mid-walk.
        set_raw(4'b0011, 4);
        bus.en = 1'b0;
        @(negedge clk);
        check("idle_fault", bus.fault, 0);
        check("idle_cnt",   bus.err_cnt, 1);
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
        repeat (3) @(negedge clk);
        set_gray(3, 4);
        set_gray(4, 4);
        u0 = up_seen;
        set_gray(5, 1);
        bus.en = 1'b0;
        @(negedge clk);
        check("drop_valid", bus.bin_valid, 0);
        repeat (4) @(negedge clk);
        check("drop_ups", up_seen - u0, 0);
        check("drop_cnt", bus.err_cnt, 1);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bin",   bus.bin_out, 0);
        check("arst_cnt",   bus.err_cnt, 0);
        check("arst_valid", bus.bin_valid, 0);
        check("arst_fault", bus.fault, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant input for 50 cycles in TRACK.
        set_gray(9, 4);
        bus.en = 1'b1;
        repeat (3) @(negedge clk);
        u0 = up_seen;
        d0 = dn_seen;
        s0 = step_seen;
        repeat (50) @(negedge clk);
        check("hold_pulses", (up_seen - u0) + (dn_seen - d0) + (step_seen - s0), 0);
        check("hold_bin",    bus.bin_out, 9);
        check("hold_valid",  bus.bin_valid, 1);

        // Random walk with occasional jumps, enable drops and clears.
        begin
            int b = 9;
            for (int n = 0; n < 600; n++) begin
                int r = int'($urandom_range(0, 15));
                if (r >= 8 && r <= 10) b = (b + 1) % M;
                else if (r == 11 || r == 12) b = (b + M - 1) % M;
                else if (r == 13) b = int'($urandom_range(0, M - 1));
                bus.gray_in = W'(b2g(b));
                bus.en      = ($urandom_range(0, 31) != 0);
                bus.clr_err = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        bus.clr_err = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
